eep_i2c_target: RTL

//   I2C target (responder) emulating a small 24Cxx-style EEPROM, the far end of the
//   bit-banged SCL/SDA PIO master on the same bus. Decodes START/STOP, matches a 7-bit

---
 rtl/eep_i2c_target.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/eep_i2c_target.sv
// I2C target emulating a small 24Cxx-style EEPROM with an auto-incrementing word pointer.
// The CPU reaches the same byte array through a zero-wait-state Avalon-MM slave port.
`timescale 1ns/1ps
module eep_i2c_target #(
   parameter logic [6:0]  DEV_ADDR = 7'h50,
   parameter int unsigned AW       = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          scl_in,
   input  logic          sda_in,
   output logic          sda_oe,
   input  logic [AW-1:0] address,
   input  logic          chipselect,
   input  logic          write_n,
   input  logic [31:0]   writedata,
   output logic [31:0]   readdata
);

   typedef enum logic [3:0] {
      IDLE, DEVA, DACK, WADR, WACK, WDAT, DWACK, RDAT, RACK
   } state_t;

   localparam int unsigned DEPTH = 2**AW;

   logic          r_sclS1, r_sclS2, r_sclD;
   logic          r_sdaS1, r_sdaS2, r_sdaD;
   state_t        r_state, w_stateNext;
   logic [3:0]    r_bitCnt, w_bitCntNext;
   logic [7:0]    r_shift, w_shiftNext;
   logic [AW-1:0] r_ptr, w_ptrNext;
   logic          r_rw, w_rwNext;
   logic          r_sdaOe, w_sdaOeNext;
   logic [7:0]    r_mem [DEPTH];

   logic          w_sclRise, w_sclFall, w_start, w_stop;
   logic [7:0]    w_byte, w_memRd;
   logic          w_memWe;
   logic          w_unused;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sclS1 <= 1'b1;
         r_sclS2 <= 1'b1;
         r_sclD  <= 1'b1;
         r_sdaS1 <= 1'b1;
         r_sdaS2 <= 1'b1;
         r_sdaD  <= 1'b1;
      end else begin
         r_sclS1 <= scl_in;
         r_sclS2 <= r_sclS1;
         r_sclD  <= r_sclS2;
         r_sdaS1 <= sda_in;
         r_sdaS2 <= r_sdaS1;
         r_sdaD  <= r_sdaS2;
      end
   end

   assign w_sclRise = r_sclS2 & ~r_sclD;
   assign w_sclFall = ~r_sclS2 & r_sclD;
   assign w_start   = r_sclS2 & r_sclD & r_sdaD & ~r_sdaS2;
   assign w_stop    = r_sclS2 & r_sclD & ~r_sdaD & r_sdaS2;

   assign w_byte  = {r_shift[6:0], r_sdaS2};
   assign w_memRd = r_mem[r_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_bitCnt <= 4'd0;
         r_shift  <= 8'd0;
         r_ptr    <= '0;
         r_rw     <= 1'b0;
         r_sdaOe  <= 1'b0;
      end else begin
         r_state  <= w_stateNext;
         r_bitCnt <= w_bitCntNext;
         r_shift  <= w_shiftNext;
         r_ptr    <= w_ptrNext;
         r_rw     <= w_rwNext;
         r_sdaOe  <= w_sdaOeNext;
      end
   end

   // In the ACK states r_sdaOe doubles as the phase flag: first SCL fall pulls, second releases.
   always_comb begin
      w_stateNext  = r_state;
      w_bitCntNext = r_bitCnt;
      w_shiftNext  = r_shift;
      w_ptrNext    = r_ptr;
      w_rwNext     = r_rw;
      w_sdaOeNext  = r_sdaOe;
      w_memWe      = 1'b0;

      case (r_state)
         DEVA: begin
            if (w_sclRise) begin
               w_shiftNext  = w_byte;
               w_bitCntNext = r_bitCnt + 4'd1;
               if (r_bitCnt == 4'd7) begin
                  w_bitCntNext = 4'd0;
                  if (w_byte[7:1] == DEV_ADDR) begin
                     w_stateNext = DACK;
                     w_rwNext    = w_byte[0];
                  end else begin
                     w_stateNext = IDLE;
                  end
               end
            end
         end
         DACK, WACK, DWACK: begin
            if (w_sclFall) begin
               if (!r_sdaOe) begin
                  w_sdaOeNext = 1'b1;
               end else begin
                  w_sdaOeNext  = 1'b0;
                  w_bitCntNext = 4'd0;
                  if (r_state == DACK && r_rw) begin
                     w_stateNext  = RDAT;
                     w_shiftNext  = {w_memRd[6:0], 1'b0};
                     w_sdaOeNext  = ~w_memRd[7];
                     w_bitCntNext = 4'd1;
                  end else if (r_state == DACK) begin
                     w_stateNext = WADR;
                  end else begin
                     w_stateNext = WDAT;
                  end
               end
            end
         end
         WADR: begin
            if (w_sclRise) begin
               w_shiftNext  = w_byte;
               w_bitCntNext = r_bitCnt + 4'd1;
               if (r_bitCnt == 4'd7) begin
                  w_bitCntNext = 4'd0;
                  w_ptrNext    = w_byte[AW-1:0];
                  w_stateNext  = WACK;
               end
            end
         end
         WDAT: begin
            if (w_sclRise) begin
               w_shiftNext  = w_byte;
               w_bitCntNext = r_bitCnt + 4'd1;
               if (r_bitCnt == 4'd7) begin
                  w_bitCntNext = 4'd0;
                  w_memWe      = 1'b1;
                  w_ptrNext    = r_ptr + AW'(1);
                  w_stateNext  = DWACK;
               end
            end
         end
         RDAT: begin
            if (w_sclFall) begin
               if (r_bitCnt == 4'd8) begin
                  w_sdaOeNext  = 1'b0;
                  w_ptrNext    = r_ptr + AW'(1);
                  w_bitCntNext = 4'd0;
                  w_stateNext  = RACK;
               end else if (r_bitCnt == 4'd0) begin
                  w_sdaOeNext  = ~w_memRd[7];
                  w_shiftNext  = {w_memRd[6:0], 1'b0};
                  w_bitCntNext = 4'd1;
               end else begin
                  w_sdaOeNext  = ~r_shift[7];
                  w_shiftNext  = {r_shift[6:0], 1'b0};
                  w_bitCntNext = r_bitCnt + 4'd1;
               end
            end
         end
         RACK: begin
            if (w_sclRise) begin
               w_bitCntNext = 4'd0;
               w_stateNext  = r_sdaS2 ? IDLE : RDAT;
            end
         end
         default: ;
      endcase

      // Bus conditions override whatever the byte-level logic decided this cycle.
      if (w_start) begin
         w_stateNext  = DEVA;
         w_bitCntNext = 4'd0;
         w_sdaOeNext  = 1'b0;
      end else if (w_stop) begin
         w_stateNext = IDLE;
         w_sdaOeNext = 1'b0;
      end
   end

   // The I2C commit is assigned last so it wins a same-cycle collision with the CPU.
   always_ff @(posedge clk) begin
      if (chipselect && !write_n)
         r_mem[address] <= writedata[7:0];
      if (w_memWe)
         r_mem[r_ptr] <= w_byte;
   end

   assign sda_oe   = r_sdaOe;
   assign readdata = {24'd0, r_mem[address]};
   assign w_unused = ^writedata[31:8];

endmodule
